jtframe_adpcm_seq: RTL and testbench



---
 rtl/jtframe_adpcm_seq.sv | 194 +++++++++++++++++++
 tb/tb_jtframe_adpcm_seq.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_adpcm_seq.sv
// rtl/jtframe_adpcm_seq.sv - multi-channel ADPCM sample sequencer sharing one ROM port
//
// Purpose: plays CH ADPCM samples at once. Each channel owns a nibble
// counter, a one-byte buffer and status flags. One round-robin fetch FSM
// fills the buffers through a single ROM port. Each channel drives one
// nibble to an external decoder.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start/stop/ack, ch  one-cycle command strobes aimed at channel ch
//   bank, loop          channel settings, latched on start
//   vclk[CH]            decoder nibble-consumed strobes
//   nib[4*CH]           current nibble per channel (0 when nothing valid)
//   busy/dec_rst        playing flag and its inverse for the decoder reset
//   done_n/irq_n        sticky end-of-sample flags (active low), and their AND
//   underrun            sticky starvation flag, cleared on start
//   rom_addr/rom_cs     ROM byte request
//   rom_data/rom_ok     ROM byte response
module jtframe_adpcm_seq #(
  parameter int CH      = 2,
  parameter int AW      = 17,
  parameter int CNTW    = 14,
  parameter int BW      = AW - CNTW + 1,
  parameter int HIFIRST = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            stop,
  input  logic            ack,
  input  logic [1:0]      ch,
  input  logic [BW-1:0]   bank,
  input  logic            loop,
  input  logic [CH-1:0]   vclk,
  output logic [4*CH-1:0] nib,
  output logic [CH-1:0]   busy,
  output logic [CH-1:0]   dec_rst,
  output logic [CH-1:0]   done_n,
  output logic            irq_n,
  output logic [CH-1:0]   underrun,
  output logic [AW-1:0]   rom_addr,
  output logic            rom_cs,
  input  logic [7:0]      rom_data,
  input  logic            rom_ok
);
  localparam int   SW     = (CH > 1) ? $clog2(CH) : 1;
  // The high nibble plays when cnt[0] matches this value.
  localparam logic HI_PAR = (HIFIRST == 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nx;

  logic [CH-1:0][CNTW-1:0] cnt;
  logic [CH-1:0][BW-1:0]   bank_r;
  logic [CH-1:0]           loop_r;
  logic [CH-1:0][7:0]      byte_buf;
  logic [CH-1:0]           bv;
  logic [CH-1:0]           hit_start, hit_stop, hit_ack;
  logic [SW-1:0]           sel, rr, pick;
  logic [SW:0]             scan_idx;
  logic                    found, drop, hit_sel, fill;

  always_comb begin
    hit_start = '0;
    hit_stop  = '0;
    hit_ack   = '0;
    for (int n = 0; n < CH; n++) begin
      hit_start[n] = start && (ch == 2'(n));
      hit_stop[n]  = stop  && (ch == 2'(n));
      hit_ack[n]   = ack   && (ch == 2'(n));
    end
  end

  // A restart or stop of the channel being fetched makes the byte in flight stale.
  assign hit_sel = (start | stop) && (32'(ch) == 32'(sel));
  assign fill    = (state == WAIT) && rom_ok && !drop && !hit_sel;

  assign dec_rst = ~busy;
  assign irq_n   = &done_n;

  always_comb begin
    nib = '0;
    for (int n = 0; n < CH; n++) begin
      if (bv[n] && busy[n])
        nib[4*n +: 4] = (cnt[n][0] == HI_PAR) ? byte_buf[n][7:4] : byte_buf[n][3:0];
    end
  end

  // Round-robin scan: search starts at the channel after the last one served.
  always_comb begin
    state_nx = state;
    found    = 1'b0;
    pick     = rr;
    scan_idx = '0;
    for (int k = 1; k <= CH; k++) begin
      scan_idx = {1'b0, rr} + (SW+1)'(k);
      if (scan_idx >= (SW+1)'(CH)) scan_idx = scan_idx - (SW+1)'(CH);
      if (!found && busy[scan_idx[SW-1:0]] && !bv[scan_idx[SW-1:0]]) begin
        found = 1'b1;
        pick  = scan_idx[SW-1:0];
      end
    end
    case (state)
      IDLE:    if (found) state_nx = REQ;
      REQ:     state_nx = WAIT;
      WAIT:    if (rom_ok) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel      <= '0;
      rr       <= '0;
      drop     <= 1'b0;
      rom_cs   <= 1'b0;
      rom_addr <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          sel      <= pick;
          rr       <= pick;
          rom_cs   <= 1'b1;
          rom_addr <= {bank_r[pick], cnt[pick][CNTW-1:1]};
          // The address was taken from the old settings if the channel restarts now.
          drop     <= (start | stop) && (32'(ch) == 32'(pick));
        end
        REQ: if (hit_sel) drop <= 1'b1;
        WAIT: begin
          if (rom_ok) begin
            rom_cs <= 1'b0;
            drop   <= 1'b0;
          end else if (hit_sel) begin
            drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      bank_r   <= '0;
      loop_r   <= '0;
      byte_buf <= '0;
      bv       <= '0;
      busy     <= '0;
      done_n   <= '1;
      underrun <= '0;
    end else begin
      for (int n = 0; n < CH; n++) begin
        if (hit_start[n]) begin
          cnt[n]      <= '0;
          bv[n]       <= 1'b0;
          busy[n]     <= 1'b1;
          done_n[n]   <= 1'b1;
          underrun[n] <= 1'b0;
          bank_r[n]   <= bank;
          loop_r[n]   <= loop;
        end else if (hit_stop[n]) begin
          busy[n] <= 1'b0;
          bv[n]   <= 1'b0;
        end else begin
          if (hit_ack[n]) done_n[n] <= 1'b1;
          if (vclk[n] && busy[n]) begin
            if (!bv[n]) begin
              underrun[n] <= 1'b1;
            end else begin
              cnt[n] <= cnt[n] + 1'b1;
              if (cnt[n][0]) bv[n] <= 1'b0;
              // End of sample overrides a same-cycle ack.
              if (&cnt[n] && !loop_r[n]) begin
                busy[n]   <= 1'b0;
                done_n[n] <= 1'b0;
              end
            end
          end
          if (fill && (sel == SW'(n))) begin
            byte_buf[n] <= rom_data;
            bv[n]       <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_jtframe_adpcm_seq.sv
// tb/tb_jtframe_adpcm_seq.sv - scoreboard bench for jtframe_adpcm_seq
module tb_jtframe_adpcm_seq;
  localparam int CH   = 2;
  localparam int AW   = 8;
  localparam int CNTW = 4;
  localparam int BW   = AW - CNTW + 1;
  localparam int LEN  = 1 << CNTW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start, stop, ack, loop;
  logic [1:0]    ch;
  logic [BW-1:0] bank;
  logic [CH-1:0] vclk;
  logic [4*CH-1:0] nib;
  logic [CH-1:0] busy, dec_rst, done_n, underrun;
  logic          irq_n, rom_cs, rom_ok;
  logic [AW-1:0] rom_addr;
  logic [7:0]    rom_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  jtframe_adpcm_seq #(.CH(CH), .AW(AW), .CNTW(CNTW), .BW(BW), .HIFIRST(1)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .ack(ack), .ch(ch),
    .bank(bank), .loop(loop), .vclk(vclk), .nib(nib), .busy(busy),
    .dec_rst(dec_rst), .done_n(done_n), .irq_n(irq_n), .underrun(underrun),
    .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok)
  );

  // ROM: byte = address, data ready one cycle after the request (unless held).
  int         cs_cnt;
  logic       rom_hold = 1'b0;
  logic [7:0] flog[$];
  assign rom_data = rom_addr;
  assign rom_ok   = rom_cs && !rom_hold && (cs_cnt >= 1);
  always @(posedge clk or posedge rst) begin
    if (rst) cs_cnt <= 0;
    else if (rom_cs && rom_ok) begin
      flog.push_back(rom_addr);
      cs_cnt <= 0;
    end else if (rom_cs) cs_cnt <= cs_cnt + 1;
    else cs_cnt <= 0;
  end

  // Reference model: one playback position per channel.
  bit         m_play[CH];
  bit         m_loop[CH];
  bit         m_starved[CH];
  int         m_pos[CH];
  int         m_bank[CH];
  logic [3:0] q0[$];
  logic [3:0] q1[$];

  function automatic logic [3:0] ref_nib(int b, int p);
    int bv;
    bv = (b * (LEN / 2) + p / 2) % 256;
    return (p % 2 == 0) ? 4'(bv / 16) : 4'(bv % 16);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic do_start(input int c, input int b, input bit l);
    @(negedge clk);
    start = 1'b1; ch = 2'(c); bank = BW'(b); loop = l;
    m_play[c] = 1'b1; m_pos[c] = 0; m_bank[c] = b; m_loop[c] = l;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop(input int c);
    @(negedge clk);
    stop = 1'b1; ch = 2'(c);
    m_play[c] = 1'b0;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic do_ack(input int c);
    @(negedge clk);
    ack = 1'b1; ch = 2'(c);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic pulse(input logic [CH-1:0] mask, input int gap);
    logic [3:0] e;
    @(negedge clk);
    vclk = mask;
    for (int n = 0; n < CH; n++) begin
      if (mask[n]) begin
        e = 4'h0;
        if (m_play[n] && !m_starved[n]) begin
          e = ref_nib(m_bank[n], m_pos[n]);
          m_pos[n]++;
          if (m_pos[n] == LEN) begin
            m_pos[n] = 0;
            if (!m_loop[n]) m_play[n] = 1'b0;
          end
        end
        if (n == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
    @(negedge clk);
    vclk = '0;
    repeat (gap) @(negedge clk);
  endtask

  // Monitor: every consumed nibble is compared with the oldest expectation.
  always @(negedge clk) begin
    #1;
    if (vclk[0] === 1'b1) begin
      if (q0.size() == 0) begin
        total++; bad++;
        $display("FAIL nib0_unexpected: got %0h want none", nib[3:0]);
      end else chk("nib0", 32'(nib[3:0]), 32'(q0.pop_front()));
    end
    if (vclk[1] === 1'b1) begin
      if (q1.size() == 0) begin
        total++; bad++;
        $display("FAIL nib1_unexpected: got %0h want none", nib[7:4]);
      end else chk("nib1", 32'(nib[7:4]), 32'(q1.pop_front()));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    start = 0; stop = 0; ack = 0; ch = 0; bank = 0; loop = 0; vclk = 0;
    for (int n = 0; n < CH; n++) begin
      m_play[n] = 0; m_loop[n] = 0; m_starved[n] = 0; m_pos[n] = 0; m_bank[n] = 0;
    end
    repeat (3) @(negedge clk);
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dec_rst", 32'(dec_rst), 3);
    chk("rst_done_n", 32'(done_n), 3);
    chk("rst_irq_n", 32'(irq_n), 1);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_nib", 32'(nib), 0);
    rst = 1'b0;
    @(negedge clk);

    // One-shot playback of bank 3
    do_start(0, 3, 0);
    chk("t1_busy", 32'(busy[0]), 1);
    chk("t1_cs_early", 32'(rom_cs), 0);
    @(negedge clk);
    chk("t2_cs", 32'(rom_cs), 1);
    chk("t2_addr", 32'(rom_addr), 32'h18);
    repeat (8) @(negedge clk);
    for (int i = 0; i < LEN - 1; i++) pulse(2'b01, 19);
    pulse(2'b01, 0);
    chk("end_done_n", 32'(done_n), 32'b10);
    chk("end_busy", 32'(busy), 0);
    chk("end_irq_n", 32'(irq_n), 0);
    chk("end_dec_rst", 32'(dec_rst), 3);
    chk("end_underrun", 32'(underrun), 0);
    do_ack(0);
    chk("ack_done_n", 32'(done_n), 3);
    chk("ack_irq_n", 32'(irq_n), 1);

    // Looping playback
    flog.delete();
    do_start(0, 3, 1);
    repeat (10) @(negedge clk);
    for (int i = 0; i < 40; i++) pulse(2'b01, 19);
    chk("loop_busy", 32'(busy[0]), 1);
    chk("loop_done_n", 32'(done_n[0]), 1);
    chk("loop_fetches", flog.size(), 21);
    for (int i = 0; i < flog.size() && i < 21; i++) chk("loop_addr", 32'(flog[i]), 32'(8'h18 + i % 8));
    do_stop(0);
    repeat (3) @(negedge clk);

    // Two channels, simultaneous consumption
    flog.delete();
    do_start(0, 3, 0);
    do_start(1, 5, 0);
    repeat (10) @(negedge clk);
    for (int i = 0; i < LEN - 1; i++) pulse(2'b11, 19);
    pulse(2'b11, 0);
    chk("rr_fetches", flog.size(), 16);
    for (int i = 0; i < flog.size() && i < 16; i++)
      chk("rr_addr", 32'(flog[i]), (i % 2 == 0) ? 32'(8'h18 + i / 2) : 32'(8'h28 + i / 2));
    chk("rr_underrun", 32'(underrun), 0);
    chk("rr_done_n", 32'(done_n), 0);
    chk("rr_busy", 32'(busy), 0);
    do_ack(0);
    do_ack(1);
    chk("rr_irq_n", 32'(irq_n), 1);

    // Starved ROM: underrun, then resume from nibble 0
    rom_hold = 1'b1;
    m_starved[0] = 1'b1;
    do_start(0, 2, 0);
    for (int i = 0; i < 5; i++) pulse(2'b01, 8);
    chk("ur_flag", 32'(underrun[0]), 1);
    chk("ur_cs", 32'(rom_cs), 1);
    chk("ur_addr", 32'(rom_addr), 32'h10);
    rom_hold = 1'b0;
    repeat (4) @(negedge clk);
    m_starved[0] = 1'b0;
    for (int i = 0; i < 4; i++) pulse(2'b01, 19);
    chk("ur_sticky", 32'(underrun[0]), 1);
    do_stop(0);
    chk("stop_busy", 32'(busy[0]), 0);
    chk("stop_done_n", 32'(done_n[0]), 1);
    chk("stop_nib", 32'(nib[3:0]), 0);

    // Restart during a fetch: stale byte dropped, refetch from new bank
    flog.delete();
    rom_hold = 1'b1;
    do_start(0, 1, 0);
    repeat (3) @(negedge clk);
    chk("drop_cs", 32'(rom_cs), 1);
    chk("drop_addr_old", 32'(rom_addr), 32'h08);
    do_start(0, 6, 0);
    repeat (2) @(negedge clk);
    rom_hold = 1'b0;
    repeat (10) @(negedge clk);
    chk("drop_fetches", flog.size(), 2);
    if (flog.size() >= 2) begin
      chk("drop_stale", 32'(flog[0]), 32'h08);
      chk("drop_new", 32'(flog[1]), 32'h30);
    end
    chk("drop_underrun", 32'(underrun[0]), 0);
    for (int i = 0; i < 4; i++) pulse(2'b01, 19);
    do_stop(0);

    // Asynchronous reset in the middle of a fetch
    rom_hold = 1'b1;
    do_start(1, 4, 0);
    w = 0;
    while (!rom_cs && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("ar_fetch_started", 32'(rom_cs), 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_rom_cs", 32'(rom_cs), 0);
    chk("ar_rom_addr", 32'(rom_addr), 0);
    chk("ar_busy", 32'(busy), 0);
    chk("ar_dec_rst", 32'(dec_rst), 3);
    chk("ar_done_n", 32'(done_n), 3);
    chk("ar_irq_n", 32'(irq_n), 1);
    chk("ar_underrun", 32'(underrun), 0);
    chk("ar_nib", 32'(nib), 0);
    for (int n = 0; n < CH; n++) m_play[n] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rom_hold = 1'b0;

    // vclk on idle channels does nothing
    pulse(2'b11, 5);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_cs", 32'(rom_cs), 0);
    chk("idle_underrun", 32'(underrun), 0);

    repeat (3) @(negedge clk);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
